// File: rtl/pwm_duty_capture_if.sv
// Signal bundle between a PWM source/consumer (master) and pwm_duty_capture (slave).
interface pwm_duty_capture_if;
   logic       pwm_in;
   logic [6:0] duty_pct;
   logic       duty_valid;
   logic       stuck;
   logic       busy;
   logic       overrun;

   modport master (output pwm_in, input duty_pct, duty_valid, stuck, busy, overrun);
   modport slave  (input pwm_in, output duty_pct, duty_valid, stuck, busy, overrun);
endinterface

// File: rtl/pwm_duty_capture.sv
// Measures period and high time of an asynchronous PWM line and reports rounded duty percent.
// Optional glitch filter on the synchronized input: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_duty_capture #(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset,
   pwm_duty_capture_if.slave cap
);
   localparam int NUM_W = CNT_W + 7;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = ~CNT_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           r_state, w_nextState;
   logic             r_sync1, r_sync2, r_sPrev;
   logic             w_s, w_rise;
   logic [CNT_W-1:0] r_periodCnt, r_highCnt;
   logic             w_timeout, w_accept, w_overrunSet;
   logic [NUM_W-1:0] r_num, r_divisor, w_shifted, w_numNext;
   logic [6:0]       r_quot, w_quotNext, w_pct, r_dutyPct;
   logic [2:0]       r_step;
   logic             r_busy, r_done, w_bit;
   logic             r_dutyValid, r_stuck, r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sPrev <= 1'b0;
      end else begin
         r_sync1 <= cap.pwm_in;
         r_sync2 <= r_sync1;
         r_sPrev <= w_s;
      end
   end

`ifdef PWM_CAP_GLITCH_FILTER_EN
   logic r_hist1, r_hist2, r_filt, w_agree;

   // The filtered level follows the line only once three consecutive samples agree.
   assign w_agree = (r_sync2 == r_hist1) && (r_sync2 == r_hist2);
   assign w_s     = w_agree ? r_sync2 : r_filt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist1 <= 1'b0;
         r_hist2 <= 1'b0;
         r_filt  <= 1'b0;
      end else begin
         r_hist1 <= r_sync2;
         r_hist2 <= r_hist1;
         r_filt  <= w_s;
      end
   end
`else
   assign w_s = r_sync2;
`endif

   assign w_rise = w_s & ~r_sPrev;

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // A rise always wins over the timeout; the divider accepts on its result cycle too.
   always_comb begin
      w_nextState  = r_state;
      w_timeout    = 1'b0;
      w_accept     = 1'b0;
      w_overrunSet = 1'b0;
      if (w_rise) begin
         w_nextState = MEASURE;
         if (r_state == MEASURE) begin
            w_accept     = !r_busy || r_done;
            w_overrunSet = r_busy && !r_done;
         end
      end else if (r_periodCnt == TIMEOUT_LAST) begin
         w_timeout   = 1'b1;
         w_nextState = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_timeout) begin
         r_periodCnt <= '0;
         r_highCnt   <= '0;
      end else if (w_rise) begin
         r_periodCnt <= CNT_W'(1);
         r_highCnt   <= CNT_W'(1);
      end else begin
         r_periodCnt <= r_periodCnt + CNT_W'(1);
         if (r_state == MEASURE) r_highCnt <= r_highCnt + CNT_W'(w_s);
      end
   end

   // Restoring division, quotient bits shifted in MSB first.
   assign w_shifted = r_divisor << r_step;
   assign w_bit     = (r_num >= w_shifted);

   always_comb begin
      w_numNext  = w_bit ? (r_num - w_shifted) : r_num;
      w_quotNext = {r_quot[5:0], w_bit};
      w_pct      = (w_quotNext > 7'd100) ? 7'd100 : w_quotNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_num       <= '0;
         r_divisor   <= '0;
         r_quot      <= '0;
         r_step      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_dutyValid <= 1'b0;
         r_dutyPct   <= '0;
         r_stuck     <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_dutyValid <= 1'b0;
         if (w_overrunSet) r_overrun <= 1'b1;
         if (w_timeout) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dutyValid <= 1'b1;
            r_stuck     <= 1'b1;
            r_dutyPct   <= w_s ? 7'd100 : 7'd0;
         end else if (w_accept) begin
            r_num     <= NUM_W'(r_highCnt) * NUM_W'(100) + NUM_W'(r_periodCnt >> 1);
            r_divisor <= NUM_W'(r_periodCnt);
            r_quot    <= '0;
            r_step    <= 3'd6;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
         end else if (r_busy && r_done) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
         end else if (r_busy) begin
            r_num  <= w_numNext;
            r_quot <= w_quotNext;
            r_step <= r_step - 3'd1;
            if (r_step == 3'd0) begin
               r_done      <= 1'b1;
               r_dutyValid <= 1'b1;
               r_stuck     <= 1'b0;
               r_dutyPct   <= w_pct;
            end
         end
      end
   end

   assign cap.duty_pct   = r_dutyPct;
   assign cap.duty_valid = r_dutyValid;
   assign cap.stuck      = r_stuck;
   assign cap.busy       = r_busy;
   assign cap.overrun    = r_overrun;
endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench for pwm_duty_capture: an event-level reference model predicts results,
// a negedge monitor compares every duty_valid pulse plus busy/overrun each cycle.
module tb_pwm_duty_capture;
   localparam int CNT_W   = 10;
   localparam int TO_LAST = (1 << CNT_W) - 2;
   localparam int MAXC    = 60000;

   logic clk = 1'b0;
   logic reset;

   pwm_duty_capture_if capIf();

   pwm_duty_capture #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .cap   (capIf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pct;
      bit stuck;
      int cyc;
   } exp_t;

   exp_t expQ[$];
   bit   pEff[MAXC];
   bit   sArr[MAXC];
   int   edgeCount  = -1;
   int   lastRise   = 0;
   int   lastAccept = -1000;
   int   refCycle   = 0;
   int   resetEdge  = 0;
   bit   measuring  = 1'b0;
   bit   expOverrun = 1'b0;
   int   checks     = 0;
   int   passes     = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, edgeCount);
   endtask

   // Level seen by the measurement logic in cycle c, from the inputs sampled at earlier edges.
   function automatic bit sFromInputs(input int c);
`ifdef PWM_CAP_GLITCH_FILTER_EN
      if (pEff[c-1] == pEff[c-2] && pEff[c-1] == pEff[c-3]) return pEff[c-1];
      return sArr[c-1];
`else
      return pEff[c-1];
`endif
   endfunction

   task automatic evaluateCycle(input int c);
      bit rise;
      int p, h, q;
      rise = sArr[c] && (c > 0) && !sArr[c-1];
      if (rise) begin
         if (measuring) begin
            p = c - lastRise;
            h = 0;
            for (int j = lastRise; j < c; j++) h += int'(sArr[j]);
            if (c >= lastAccept + 8) begin
               q = (h * 100 + p / 2) / p;
               if (q > 100) q = 100;
               expQ.push_back('{q, 1'b0, c + 8});
               lastAccept = c;
            end else begin
               expOverrun = 1'b1;
            end
         end
         measuring = 1'b1;
         lastRise  = c;
         refCycle  = c;
      end else if (c - refCycle == TO_LAST) begin
         while (expQ.size() > 0 && expQ[$].cyc > c + 1) void'(expQ.pop_back());
         expQ.push_back('{(sArr[c] ? 100 : 0), 1'b1, c + 1});
         measuring  = 1'b0;
         lastAccept = -1000;
         refCycle   = c + 1;
      end
   endtask

   initial forever begin
      @(posedge clk);
      edgeCount++;
      if (edgeCount >= MAXC) begin
         $display("[TB] FAIL model_capacity: cycle %0d exceeds %0d", edgeCount, MAXC);
         $fatal(1, "[TB] model out of range");
      end
      if (reset) begin
         pEff[edgeCount] = 1'b0;
         if (edgeCount >= 1) pEff[edgeCount-1] = 1'b0;
         if (edgeCount >= 2) pEff[edgeCount-2] = 1'b0;
         sArr[edgeCount] = 1'b0;
         expQ.delete();
         expOverrun = 1'b0;
         lastAccept = -1000;
         measuring  = 1'b0;
         refCycle   = edgeCount;
         resetEdge  = edgeCount;
      end else begin
         pEff[edgeCount] = capIf.pwm_in;
         if (edgeCount - 1 > resetEdge) sArr[edgeCount-1] = sFromInputs(edgeCount - 1);
         if (edgeCount - 1 >= resetEdge) evaluateCycle(edgeCount - 1);
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (edgeCount >= 0) begin
         checkOutput("busy", int'(capIf.busy), int'((edgeCount > lastAccept) && (edgeCount <= lastAccept + 8)));
         checkOutput("overrun", int'(capIf.overrun), int'(expOverrun));
         if (capIf.duty_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_duty_valid", int'(capIf.duty_pct), -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("duty_pct", int'(capIf.duty_pct), e.pct);
               checkOutput("stuck", int'(capIf.stuck), int'(e.stuck));
               checkOutput("result_cycle", edgeCount, e.cyc);
            end
         end else if (expQ.size() > 0 && expQ[0].cyc <= edgeCount) begin
            e = expQ.pop_front();
            checkOutput("missed_duty_valid", edgeCount, e.cyc);
         end
      end
   end

   task automatic applyStimulus(input bit level, input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         capIf.pwm_in = level;
      end
   endtask

   task automatic periods(input int period, input int high, input int n);
      repeat (n) begin
         applyStimulus(1'b1, high);
         applyStimulus(1'b0, period - high);
      end
   endtask

   task automatic checkResetState();
      checkOutput("reset_duty_pct", int'(capIf.duty_pct), 0);
      checkOutput("reset_duty_valid", int'(capIf.duty_valid), 0);
      checkOutput("reset_stuck", int'(capIf.stuck), 0);
      checkOutput("reset_busy", int'(capIf.busy), 0);
      checkOutput("reset_overrun", int'(capIf.overrun), 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int per, hi;
      reset        = 1'b1;
      capIf.pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkResetState();

      periods(256, 128, 4);
      periods(256, 3, 3);
      periods(256, 253, 3);
      periods(256, 255, 3);

      periods(4, 1, 12);
      checkOutput("overrun_after_fast_pwm", int'(capIf.overrun), 1);

      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b0, 2);
      reset = 1'b0;
      checkResetState();

      for (int seg = 0; seg < 15; seg++) begin
         per = $urandom_range(300, 2);
         hi  = $urandom_range(per - 1, 1);
         periods(per, hi, $urandom_range(4, 2));
      end
      for (int b = 0; b < 200; b++) applyStimulus(1'(b % 2), $urandom_range(6, 1));

      applyStimulus(1'b0, 2200);
      applyStimulus(1'b1, 2200);
      applyStimulus(1'b0, 128);

      periods(256, 128, 2);
      applyStimulus(1'b1, 4);
      reset = 1'b1;
      applyStimulus(1'b1, 2);
      reset = 1'b0;
      checkResetState();
      applyStimulus(1'b1, 122);
      applyStimulus(1'b0, 128);
      periods(256, 128, 3);

      repeat (3) begin
         applyStimulus(1'b1, 128);
         applyStimulus(1'b0, 62);
         applyStimulus(1'b1, 1);
         applyStimulus(1'b0, 65);
      end
      periods(256, 128, 2);

      applyStimulus(1'b0, 20);
      checkOutput("pending_results", expQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
